// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared types and constants for the FIFO drain arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_WAIT,
    ST_CAP,
    ST_OUT
  } state_t;

  localparam logic [3:0] POP_FLAG_EMPTY = 4'h0;
  localparam int         CH_ID_W        = 3;

  // Round-robin successor of a channel index, wrapping at num_ch.
  function automatic logic [CH_ID_W-1:0] next_ch(input logic [CH_ID_W-1:0] ch,
                                                 input int num_ch);
    if (int'(ch) >= num_ch - 1) begin
      return '0;
    end
    return ch + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// FIFO bank pop side plus drained-word stream, bundled as one bus.
// Latency: n/a (wires only).
// Backpressure: out_ready stalls the stream; the FIFO side has none.
interface fifo_drain_arbiter_if #(
  parameter int NUM_CH    = 3,
  parameter int DATAWIDTH = 32
);
  import fifo_arb_pkg::*;

  logic [NUM_CH-1:0]           pop;
  logic [4*NUM_CH-1:0]         pop_flag;
  logic [DATAWIDTH*NUM_CH-1:0] fifo_dout;
  logic [DATAWIDTH-1:0]        out_data;
  logic [CH_ID_W-1:0]          out_ch;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output pop,
    input  pop_flag,
    input  fifo_dout,
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  pop,
    output pop_flag,
    output fifo_dout,
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// Round-robin first-set finder: first request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_ID_W-1:0] ptr,
  output logic [NUM_CH-1:0]  gnt,
  output logic [CH_ID_W-1:0] idx,
  output logic               any
);

  // Two passes: channels ptr..NUM_CH-1 first, then the wrapped 0..ptr-1.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (!any && req[j] && (CH_ID_W'(j) >= ptr)) begin
        any    = 1'b1;
        idx    = CH_ID_W'(j);
        gnt[j] = 1'b1;
      end
    end
    for (int j = 0; j < NUM_CH; j++) begin
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = CH_ID_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin drain of a FIFO bank onto a valid/ready stream with channel ID.
// Latency: request in IDLE at t -> pop at t+1 -> out_valid at t+2+RD_LAT.
// Backpressure: out_ready low holds OUT with data stable; no pop until handoff.
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int DATAWIDTH = 32,
  parameter int RD_LAT    = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RSTn_i,
  input  logic [NUM_CH-1:0]    ch_en_i,
  input  logic                 abort_i,
  fifo_drain_arbiter_if.master bus,
  output logic [NUM_CH-1:0]    grant_o,
  output logic                 busy_o,
  output logic [15:0]          word_cnt_o
);

  localparam logic [7:0] WAIT_INIT = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;
  localparam logic [8:0] BURST_MAX = 9'(BURST_LEN);

  state_t               state_q, state_d;
  logic [NUM_CH-1:0]    req;
  logic                 req_g;
  logic [NUM_CH-1:0]    gnt_q;
  logic [CH_ID_W-1:0]   gidx_q;
  logic [CH_ID_W-1:0]   rr_ptr_q;
  logic [7:0]           burst_q;
  logic [7:0]           wait_q;
  logic [DATAWIDTH-1:0] data_q;
  logic [CH_ID_W-1:0]   ch_q;
  logic [15:0]          cnt_q;
  logic [DATAWIDTH-1:0] sel_dout;
  logic [NUM_CH-1:0]    pick_gnt;
  logic [CH_ID_W-1:0]   pick_idx;
  logic                 pick_any;
  logic                 take_grant;
  logic                 xfer;
  logic                 cont_burst;
  logic [NUM_CH-1:0]    pop_d;
  logic                 valid_d;

  // A channel requests when enabled and its FIFO flag reports non-empty.
  always_comb begin
    req = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      req[k] = ch_en_i[k] & (bus.pop_flag[4*k +: 4] != POP_FLAG_EMPTY);
    end
  end

  assign req_g = |(req & gnt_q);

  // Mux the granted FIFO's DOUT for capture.
  always_comb begin
    sel_dout = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_q[k]) begin
        sel_dout = bus.fifo_dout[DATAWIDTH*k +: DATAWIDTH];
      end
    end
  end

  rr_pick #(.NUM_CH(NUM_CH)) u_rr_pick (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state and strobes; abort overrides everything including a transfer.
  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    xfer       = 1'b0;
    cont_burst = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            take_grant = 1'b1;
            state_d    = ST_POP;
          end
        end
        ST_POP:  state_d = (RD_LAT > 1) ? ST_WAIT : ST_CAP;
        ST_WAIT: begin
          if (wait_q == 8'd0) begin
            state_d = ST_CAP;
          end
        end
        ST_CAP:  state_d = ST_OUT;
        ST_OUT: begin
          if (bus.out_ready) begin
            xfer       = 1'b1;
            cont_burst = (({1'b0, burst_q} + 9'd1) < BURST_MAX) && req_g;
            state_d    = cont_burst ? ST_POP : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pop and valid follow the state; abort suppresses both in its own cycle.
  always_comb begin
    pop_d   = '0;
    valid_d = 1'b0;
    if (!abort_i) begin
      if (state_q == ST_POP) begin
        pop_d = gnt_q;
      end
      valid_d = (state_q == ST_OUT);
    end
  end

  // State register.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, burst and read-latency counters; grant drops whenever IDLE is next.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      gnt_q   <= '0;
      gidx_q  <= '0;
      burst_q <= '0;
      wait_q  <= '0;
    end else begin
      if (take_grant) begin
        gnt_q   <= pick_gnt;
        gidx_q  <= pick_idx;
        burst_q <= '0;
      end else if (state_d == ST_IDLE) begin
        gnt_q <= '0;
      end
      if (xfer) begin
        burst_q <= burst_q + 8'd1;
      end
      if (state_q == ST_POP) begin
        wait_q <= WAIT_INIT;
      end else if (state_q == ST_WAIT && wait_q != 8'd0) begin
        wait_q <= wait_q - 8'd1;
      end
    end
  end

  // Output word capture, delivered-word count and round-robin pointer.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RSTn_i) begin
    if (!WBs_RSTn_i) begin
      data_q   <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (state_q == ST_CAP && !abort_i) begin
        data_q <= sel_dout;
        ch_q   <= gidx_q;
      end
      if (xfer) begin
        cnt_q <= cnt_q + 16'd1;
        if (!cont_burst) begin
          rr_ptr_q <= next_ch(gidx_q, NUM_CH);
        end
      end
    end
  end

  assign bus.pop       = pop_d;
  assign bus.out_valid = valid_d;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
  assign grant_o       = gnt_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign word_cnt_o    = cnt_q;

endmodule
